// File: rtl/bit_reverse_sequencer_pkg.sv
// ============================================================================
// Module   : bit_reverse_sequencer_pkg
// Brief    : Shared state encoding, sizes and ASCII constants for the
//            bit-reversal message sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_reverse_sequencer_pkg;

  localparam int NUM_BITS_DEF = 8;
  localparam int MSG_LEN_DEF  = 10;
  localparam int ADDR_W_DEF   = 4;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    LATCH   = 3'd3,
    SEND    = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  function automatic logic is_bit_char(input logic [7:0] c);
    return (c == CH_0) || (c == CH_1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_reverse_sequencer_rx_bit_filter.sv
// ============================================================================
// Module   : rx_bit_filter
// Brief    : Classifies received bytes as ASCII '0'/'1' and produces the
//            registered one-cycle RAM write strobe or a drop pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_bit_filter
  import bit_reverse_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  input  logic              enable,
  input  logic [ADDR_W-1:0] bit_cnt,
  output logic              accept,
  output logic              ram_byte_in,
  output logic [ADDR_W-1:0] ram_counter,
  output logic              ram_new_rx_data,
  output logic              rx_dropped
);

  logic              w_is_bit;
  logic              w_accept;
  logic              r_byte_in;
  logic [ADDR_W-1:0] r_counter;
  logic              r_wr_strobe;
  logic              r_dropped;

  assign w_is_bit = is_bit_char(rx_data);
  assign w_accept = new_rx_data && enable && w_is_bit;

  // Index and value are forced to zero outside write cycles so the RAM holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_byte_in   <= 1'b0;
      r_counter   <= '0;
      r_wr_strobe <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_byte_in   <= w_accept ? rx_data[0] : 1'b0;
      r_counter   <= w_accept ? bit_cnt : '0;
      r_wr_strobe <= w_accept;
      r_dropped   <= new_rx_data && !w_accept;
    end
  end

  assign accept          = w_accept;
  assign ram_byte_in     = r_byte_in;
  assign ram_counter     = r_counter;
  assign ram_new_rx_data = r_wr_strobe;
  assign rx_dropped      = r_dropped;

endmodule

`default_nettype wire

// File: rtl/bit_reverse_sequencer.sv
// ============================================================================
// Module   : bit_reverse_sequencer
// Brief    : Collects ASCII bits into the reversal RAM, then reads the whole
//            message back and streams it to the serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_reverse_sequencer
  import bit_reverse_sequencer_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int MSG_LEN  = MSG_LEN_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  output logic              ram_byte_in,
  output logic [ADDR_W-1:0] ram_counter,
  output logic              ram_new_rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              busy,
  output logic              rx_dropped
);

  localparam logic [ADDR_W-1:0] C_LAST_BIT = ADDR_W'(NUM_BITS - 1);
  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(MSG_LEN - 1);

  state_t            r_state_q,    w_state_d;
  logic [ADDR_W-1:0] r_bit_cnt_q,  w_bit_cnt_d;
  logic [ADDR_W-1:0] r_idx_q,      w_idx_d;
  logic [ADDR_W-1:0] r_ram_addr_q, w_ram_addr_d;
  logic [7:0]        r_tx_data_q,  w_tx_data_d;
  logic              r_new_tx_q,   w_new_tx_d;
  logic              r_busy_q,     w_busy_d;
  logic              r_pending_q,  w_pending_d;
  logic              w_collect_en;
  logic              w_accept;

  // The final bit's write cycle must finish before printing starts, so a
  // pending flag holds COLLECT for that one cycle while refusing new input.
  assign w_collect_en = (r_state_q == COLLECT) && !r_pending_q;

  rx_bit_filter #(
    .ADDR_W (ADDR_W)
  ) u_rx_bit_filter (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .new_rx_data     (new_rx_data),
    .enable          (w_collect_en),
    .bit_cnt         (r_bit_cnt_q),
    .accept          (w_accept),
    .ram_byte_in     (ram_byte_in),
    .ram_counter     (ram_counter),
    .ram_new_rx_data (ram_new_rx_data),
    .rx_dropped      (rx_dropped)
  );

  always_comb begin
    w_state_d    = r_state_q;
    w_bit_cnt_d  = r_bit_cnt_q;
    w_idx_d      = r_idx_q;
    w_ram_addr_d = r_ram_addr_q;
    w_tx_data_d  = r_tx_data_q;
    w_new_tx_d   = 1'b0;
    w_busy_d     = r_busy_q;
    w_pending_d  = r_pending_q;

    case (r_state_q)
      COLLECT: begin
        if (r_pending_q) begin
          w_pending_d = 1'b0;
          w_idx_d     = '0;
          w_busy_d    = 1'b1;
          w_state_d   = FETCH;
        end else if (w_accept) begin
          if (r_bit_cnt_q == C_LAST_BIT) begin
            w_bit_cnt_d = '0;
            w_pending_d = 1'b1;
          end else begin
            w_bit_cnt_d = r_bit_cnt_q + 1'b1;
          end
        end
      end
      FETCH: begin
        w_ram_addr_d = r_idx_q;
        w_state_d    = WAIT;
      end
      WAIT: begin
        w_state_d = LATCH;
      end
      LATCH: begin
        w_tx_data_d = ram_data;
        w_state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          w_new_tx_d = 1'b1;
          w_state_d  = GAP;
        end
      end
      GAP: begin
        if (r_idx_q == C_LAST_IDX) begin
          w_ram_addr_d = '0;
          w_busy_d     = 1'b0;
          w_state_d    = COLLECT;
        end else begin
          w_idx_d   = r_idx_q + 1'b1;
          w_state_d = FETCH;
        end
      end
      default: begin
        w_busy_d  = 1'b0;
        w_state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q    <= COLLECT;
      r_bit_cnt_q  <= '0;
      r_idx_q      <= '0;
      r_ram_addr_q <= '0;
      r_tx_data_q  <= 8'h00;
      r_new_tx_q   <= 1'b0;
      r_busy_q     <= 1'b0;
      r_pending_q  <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_bit_cnt_q  <= w_bit_cnt_d;
      r_idx_q      <= w_idx_d;
      r_ram_addr_q <= w_ram_addr_d;
      r_tx_data_q  <= w_tx_data_d;
      r_new_tx_q   <= w_new_tx_d;
      r_busy_q     <= w_busy_d;
      r_pending_q  <= w_pending_d;
    end
  end

  assign tx_data     = r_tx_data_q;
  assign new_tx_data = r_new_tx_q;
  assign ram_addr    = r_ram_addr_q;
  assign busy        = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_reverse_sequencer.sv
// ============================================================================
// Module   : tb_bit_reverse_sequencer
// Brief    : Scoreboard bench with a reversing RAM model for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_reverse_sequencer;
  import bit_reverse_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       ram_byte_in;
  logic [3:0] ram_counter;
  logic       ram_new_rx_data;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       busy;
  logic       rx_dropped;

  int         total = 0;
  int         bad = 0;
  int         n_strobes = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[0:15];
  logic       msg[0:7];
  int         bit_idx = 0;
  int         base;

  always #5 clk = ~clk;

  bit_reverse_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .new_rx_data     (new_rx_data),
    .tx_busy         (tx_busy),
    .tx_data         (tx_data),
    .new_tx_data     (new_tx_data),
    .ram_byte_in     (ram_byte_in),
    .ram_counter     (ram_counter),
    .ram_new_rx_data (ram_new_rx_data),
    .ram_addr        (ram_addr),
    .ram_data        (ram_data),
    .busy            (busy),
    .rx_dropped      (rx_dropped)
  );

  // Reversal RAM: bit index i lands at address 7-i; addresses 8/9 hold LF/CR.
  always @(posedge clk) begin
    if (!rst) begin
      mem[8] <= CH_LF;
      mem[9] <= CH_CR;
    end else if (ram_new_rx_data) begin
      mem[4'd7 - ram_counter] <= ram_byte_in ? 8'h31 : 8'h30;
    end
    ram_data <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (new_tx_data) begin
        n_strobes++;
        check("strobe_while_tx_busy", 32'(tx_busy), 32'd0);
        check("strobe_back_to_back", 32'(prev_strobe), 32'd0);
        check("tx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_strobe = new_tx_data;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit exp_acc);
    rx_data     = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
    check("ram_write_strobe", 32'(ram_new_rx_data), 32'(exp_acc));
    check("rx_dropped", 32'(rx_dropped), 32'(!exp_acc));
    if (exp_acc) begin
      check("ram_counter", 32'(ram_counter), 32'(bit_idx));
      check("ram_byte_in", 32'(ram_byte_in), 32'(b[0]));
      msg[bit_idx] = b[0];
      if (bit_idx == 7) begin
        for (int i = 7; i >= 0; i--) exp_q.push_back(msg[i] ? 8'h31 : 8'h30);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
        bit_idx = 0;
      end else begin
        bit_idx++;
      end
    end
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], (s[i] == 8'h30) || (s[i] == 8'h31));
  endtask

  task automatic wait_strobes(input int target);
    for (int i = 0; i < 400 && n_strobes < target; i++) tick();
    check("strobe_timeout", 32'(n_strobes >= target), 32'd1);
  endtask

  task automatic wait_done(input int start);
    wait_strobes(start + 10);
    tick();
    tick();
    check("busy_after_msg", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("strobes_per_msg", 32'(n_strobes - start), 32'd10);
  endtask

  initial begin
    rst         = 1'b0;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    tx_busy     = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_new_tx_data", 32'(new_tx_data), 32'd0);
    check("rst_ram_wr", 32'(ram_new_rx_data), 32'd0);
    check("rst_ram_byte_in", 32'(ram_byte_in), 32'd0);
    check("rst_ram_counter", 32'(ram_counter), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_dropped", 32'(rx_dropped), 32'd0);
    rst = 1'b1;
    tick();

    // Plain message with an idle transmitter.
    base = n_strobes;
    send_str("10110001");
    wait_done(base);

    // Non-bit byte mid-message, then bytes arriving during and at the end of printing.
    base = n_strobes;
    send_str("1x0");
    send_str("011010");
    for (int i = 0; i < 20 && !busy; i++) tick();
    check("busy_during_print", 32'(busy), 32'd1);
    send(8'h31, 1'b0);
    wait_strobes(base + 10);
    send(8'h31, 1'b0);
    check("busy_after_final_gap", 32'(busy), 32'd0);
    check("queue_drained_b", 32'(exp_q.size()), 32'd0);

    // Transmitter held busy while the fourth byte is pending.
    base = n_strobes;
    send_str("11100100");
    wait_strobes(base + 3);
    tick();
    tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_strobe_while_busy", 32'(new_tx_data), 32'd0);
      if (i >= 3) check("tx_data_stable", 32'(tx_data), 32'(exp_q[0]));
    end
    tx_busy = 1'b0;
    tick();
    check("strobe_after_release", 32'(new_tx_data), 32'd1);
    wait_done(base);

    // Reset during the fifth byte aborts the message.
    base = n_strobes;
    send_str("01010101");
    wait_strobes(base + 5);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("abort_new_tx_data", 32'(new_tx_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ram_addr", 32'(ram_addr), 32'd0);
    rst     = 1'b1;
    bit_idx = 0;
    base    = n_strobes;
    repeat (30) tick();
    check("no_tx_after_abort", 32'(n_strobes), 32'(base));

    // Message after the abort prints in full.
    base = n_strobes;
    send_str("00001111");
    wait_done(base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
